mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port data/instruction memory between the instruction-fetch requester and the load/store requester of the RV32I core.
- Used by the multicycle/stalling variant of the core, where fetch and data access are no longer separate combinational memories.
- Provides per-port request/grant handshakes and per-port response pulses.
- Applies data-priority arbitration with an anti-starvation counter, checks alignment, and enforces a memory timeout watchdog.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before fetch is forced to win. Minimum 1.
- TIMEOUT, 64: cycles to wait for mem_ready before aborting with an error. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request. Held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle fetch response pulse.
- if_rdata  out  32  fetched word. Valid with if_rvalid.
- if_err  out  1  fetch error (misaligned or timeout). Valid with if_rvalid.
- d_req  in  1  data request. Held with d_we, d_addr, d_wdata and d_funct3 until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_funct3  in  3  RV32I load/store size code.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle data response pulse. Also pulses as the store acknowledge.
- d_rdata  out  32  load data. 0 for stores and errors.
- d_err  out  1  data error. Valid with d_rvalid.
- mem_req  out  1  memory request. Held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_funct3  out  3  size code forwarded to the memory (fetch uses 010).
- mem_ready  in  1  memory done. mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: every output is 0; state = IDLE; starvation counter and timeout counter = 0. Reset is asynchronous, so asserting it mid-transaction drops mem_req immediately. The abandoned memory access is discarded and no response is issued.
- States: IDLE, WAIT, RESP.
- Arbitration happens in IDLE and in RESP, so back-to-back transactions are possible.
  - Only one of if_req / d_req pending: that port wins.
  - Both pending: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- gnt is combinational from state and req, and asserts for exactly one cycle per request. At that clock edge the request fields and the port id are latched.
- Starvation counter:
  - Increments on each data grant made while if_req is high, saturating at STARVE_LIMIT.
  - Clears on any fetch grant.
  - Clears on a data grant made while if_req is low.
- Alignment check on the granted request (combinational):
  - Fetch: error if addr[1:0] != 0.
  - Data: funct3 000/100 are always aligned; 001/101 require addr[0] == 0; 010 requires addr[1:0] == 0; 011, 110 and 111 are always errors.
  - On error: no mem_req is issued; next state is RESP with err = 1.
- WAIT:
  - mem_req = 1 with the latched fields.
  - On mem_ready: capture mem_rdata (loads and fetches only) and go to RESP.
  - Timeout counter clears on entry and increments each WAIT cycle. When TIMEOUT != 0 and the count reaches TIMEOUT - 1 without mem_ready: drop mem_req and go to RESP with err = 1.
  - If mem_ready and the timeout fire in the same cycle, mem_ready wins: the response is good.
- RESP:
  - rvalid pulses on the latched port for one cycle, with rdata and err. rdata is 0 on error or on a store.
  - Next state is WAIT or RESP if a new grant is made in this cycle, otherwise IDLE.
- Latency: grant to rvalid is 2 cycles with mem_ready in the first WAIT cycle, and 1 cycle on an alignment error. Maximum throughput is one transaction every 2 cycles.
- mem_* outputs hold their last value while mem_req = 0. mem_req never asserts outside WAIT.
- Outputs of the non-selected port are 0.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - funct3 size constants: F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - State encoding: IDLE, WAIT, RESP.
  - Port-id constants: PORT_IF, PORT_D.
- One sub-module, access_align_check: inputs addr[1:0], funct3 and is_fetch; output misaligned. Purely combinational and reused by the future exception unit.

Test Plan:
- Single load, addr 0x100, funct3 010, mem_ready on the first WAIT cycle, mem_rdata 0xDEADBEEF -> d_gnt at T0, mem_req at T1, d_rvalid at T2 with d_rdata 0xDEADBEEF and d_err = 0.
- if_req and d_req held high continuously, STARVE_LIMIT = 4 -> grant order D,D,D,D,IF,D,D,D,D,IF; each grant pulses once.
- Store with funct3 001 and addr 0x203 -> no mem_req; d_rvalid the cycle after d_gnt with d_err = 1 and d_rdata = 0. Also cover funct3 011 at addr 0x0 -> d_err = 1.
- Fetch with mem_ready held low, TIMEOUT = 8 -> mem_req high for 8 cycles then low; if_rvalid with if_err = 1; next request is serviced normally.
- mem_ready arriving in the same cycle the timeout fires -> good response, err = 0, data captured.
- rst_n driven low for 1 cycle during WAIT -> mem_req drops asynchronously; no rvalid ever issued; after reset, if_req at 0x0 is serviced with if_gnt and then if_rvalid.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared memory-access constants for the RV32I memory path
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

endpackage

// File: rtl/access_align_check.sv
// rtl/access_align_check.sv - combinational alignment check for fetch and load/store accesses
module access_align_check
    import riscv_mem_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] funct3,
    input  logic       is_fetch,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        if (is_fetch) begin
            misaligned = (addr != 2'b00);
        end else begin
            case (funct3)
                F3_B, F3_BU: misaligned = 1'b0;
                F3_H, F3_HU: misaligned = addr[0];
                F3_W:        misaligned = (addr != 2'b00);
                // 011, 110, 111 have no RV32I meaning
                default:     misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store requesters
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int              SW           = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX   = SW'(STARVE_LIMIT);
    localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic            TIMEOUT_EN   = (TIMEOUT != 0);

    state_t          state;
    port_t           port;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     tcnt;

    logic            arb_ok;
    logic            pick_if;
    logic            pick_d;
    logic            grant;
    logic            misaligned;
    logic            g_we;
    logic [31:0]     g_addr;
    logic [31:0]     g_wdata;
    logic [2:0]      g_funct3;

    logic            resp_fire;
    port_t           resp_port;
    logic            resp_err;
    logic [31:0]     resp_data;

    // Grants are gated by rst_n so every output reads 0 while reset is held
    always_comb begin
        arb_ok  = rst_n && ((state == IDLE) || (state == RESP));
        pick_if = if_req && (!d_req || (starve_cnt == STARVE_MAX));
        pick_d  = d_req && !pick_if;
        if_gnt  = arb_ok && pick_if;
        d_gnt   = arb_ok && pick_d;
        grant   = if_gnt || d_gnt;
        if (pick_if) begin
            g_we     = 1'b0;
            g_addr   = if_addr;
            g_wdata  = 32'd0;
            g_funct3 = F3_W;
        end else begin
            g_we     = d_we;
            g_addr   = d_addr;
            g_wdata  = d_wdata;
            g_funct3 = d_funct3;
        end
    end

    access_align_check u_align (
        .addr       (g_addr[1:0]),
        .funct3     (g_funct3),
        .is_fetch   (pick_if),
        .misaligned (misaligned)
    );

    // mem_ready beats a timeout landing in the same cycle
    always_comb begin
        resp_fire = 1'b0;
        resp_port = port;
        resp_err  = 1'b0;
        resp_data = 32'd0;
        if (state == WAIT) begin
            if (mem_ready) begin
                resp_fire = 1'b1;
                resp_data = mem_we ? 32'd0 : mem_rdata;
            end else if (TIMEOUT_EN && (tcnt == TIMEOUT_LAST)) begin
                resp_fire = 1'b1;
                resp_err  = 1'b1;
            end
        end else if (grant && misaligned) begin
            resp_fire = 1'b1;
            resp_port = pick_if ? PORT_IF : PORT_D;
            resp_err  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            port       <= PORT_IF;
            starve_cnt <= '0;
            tcnt       <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
        end else begin
            if_rvalid <= resp_fire && (resp_port == PORT_IF);
            if_err    <= resp_fire && (resp_port == PORT_IF) && resp_err;
            if_rdata  <= (resp_fire && (resp_port == PORT_IF)) ? resp_data : 32'd0;
            d_rvalid  <= resp_fire && (resp_port == PORT_D);
            d_err     <= resp_fire && (resp_port == PORT_D) && resp_err;
            d_rdata   <= (resp_fire && (resp_port == PORT_D)) ? resp_data : 32'd0;

            if (if_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt) begin
                if (!if_req)
                    starve_cnt <= '0;
                else if (starve_cnt != STARVE_MAX)
                    starve_cnt <= starve_cnt + SW'(1);
            end

            case (state)
                WAIT: begin
                    if (resp_fire) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                default: begin
                    if (grant) begin
                        port <= pick_if ? PORT_IF : PORT_D;
                        if (misaligned) begin
                            state <= RESP;
                        end else begin
                            state      <= WAIT;
                            tcnt       <= '0;
                            mem_req    <= 1'b1;
                            mem_we     <= g_we;
                            mem_addr   <= g_addr;
                            mem_wdata  <= g_wdata;
                            mem_funct3 <= g_funct3;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int          mem_delay = 0;
    int          wait_cycles = 0;
    logic        use_ovr = 1'b0;
    logic [31:0] ovr_data = '0;

    mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory model: answers after mem_delay cycles of mem_req being high
    always @(negedge clk) begin
        if (mem_req) begin
            if (wait_cycles == mem_delay) begin
                mem_ready = 1'b1;
                mem_rdata = use_ovr ? ovr_data : mem_word(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            wait_cycles++;
        end else begin
            mem_ready   = 1'b0;
            wait_cycles = 0;
        end
    end

    function automatic bit ref_misaligned(input bit is_fetch, input logic [31:0] addr,
                                          input logic [2:0] f3);
        int size;
        if (is_fetch) size = 4;
        else begin
            case (f3)
                3'd0, 3'd4: size = 1;
                3'd1, 3'd5: size = 2;
                3'd2:       size = 4;
                default:    return 1'b1;
            endcase
        end
        return (addr % size) != 0;
    endfunction

    task automatic run_txn(input bit is_fetch, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           input int delay, input string name);
        bit          mis, exp_err, fld_bad, other_bad;
        logic [31:0] exp_data, got_data;
        logic        got_err, got_mreq;
        int          exp_lat, exp_mreq, lat, mreq_cnt;
        mis      = ref_misaligned(is_fetch, addr, f3);
        exp_err  = mis || (delay >= TO);
        exp_data = (exp_err || (we && !is_fetch)) ? 32'd0 : (use_ovr ? ovr_data : mem_word(addr));
        exp_lat  = mis ? 1 : ((delay < TO) ? delay + 2 : TO + 1);
        exp_mreq = mis ? 0 : ((delay < TO) ? delay + 1 : TO);
        @(posedge clk); #1;
        mem_delay = delay;
        if (is_fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3;
        end
        @(negedge clk);
        tests++;
        if ((is_fetch ? if_gnt : d_gnt) !== 1'b1 || (is_fetch ? d_gnt : if_gnt) !== 1'b0) begin
            fails++;
            $display("FAIL %s grant: if_gnt=%b d_gnt=%b want fetch=%0d only", name, if_gnt, d_gnt, is_fetch);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_funct3 = 3'($urandom);
        lat = 0; mreq_cnt = 0; fld_bad = 0; other_bad = 0;
        got_data = '0; got_err = 1'b0; got_mreq = 1'b0;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            if (mem_req) begin
                mreq_cnt++;
                if (mem_addr !== addr || mem_we !== (is_fetch ? 1'b0 : we) ||
                    mem_funct3 !== (is_fetch ? F3_W : f3) ||
                    (!is_fetch && we && mem_wdata !== wdata))
                    fld_bad = 1;
            end
            if ((is_fetch ? d_rvalid : if_rvalid) !== 1'b0) other_bad = 1;
            if ((is_fetch ? if_rvalid : d_rvalid) === 1'b1) begin
                lat      = k;
                got_data = is_fetch ? if_rdata : d_rdata;
                got_err  = is_fetch ? if_err : d_err;
                got_mreq = mem_req;
                if ((is_fetch ? {d_rdata, d_err} : {if_rdata, if_err}) !== 33'd0) other_bad = 1;
                break;
            end
        end
        tests++;
        if (lat != exp_lat) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        tests++;
        if (mreq_cnt != exp_mreq) begin
            fails++; $display("FAIL %s mem_req_cycles: got %0d want %0d", name, mreq_cnt, exp_mreq);
        end
        tests++;
        if (got_err !== exp_err) begin
            fails++; $display("FAIL %s err: got %b want %b", name, got_err, exp_err);
        end
        tests++;
        if (got_data !== exp_data) begin
            fails++; $display("FAIL %s rdata: got %08h want %08h", name, got_data, exp_data);
        end
        tests++;
        if (fld_bad || other_bad || got_mreq !== 1'b0) begin
            fails++;
            $display("FAIL %s fields: mem_field_bad=%0d other_port_bad=%0d mem_req_at_resp=%b want 0 0 0",
                     name, fld_bad, other_bad, got_mreq);
        end
        @(negedge clk);
        tests++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s after_resp: if_rvalid=%b d_rvalid=%b busy=%b want 0 0 0",
                     name, if_rvalid, d_rvalid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h80; d_funct3 = F3_W;
        repeat (2) @(negedge clk);
        tests++;
        if ({if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err, mem_req,
             mem_we, mem_addr, mem_wdata, mem_funct3, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: if_gnt=%b d_gnt=%b mem_req=%b mem_addr=%08h busy=%b want all 0",
                     if_gnt, d_gnt, mem_req, mem_addr, busy);
        end
        if_req = 1'b0; d_req = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        use_ovr = 1'b1; ovr_data = 32'hDEADBEEF;
        run_txn(0, 0, 32'h100, 32'h0, F3_W, 0, "single_load");
        use_ovr = 1'b0;
    endtask

    task automatic test_starvation();
        int  cnt, n;
        bit  exp_if, prev;
        cnt = 0; n = 0; prev = 0;
        @(posedge clk); #1;
        mem_delay = 0;
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_funct3 = F3_W;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                exp_if = (cnt == SL);
                tests++;
                if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                    fails++;
                    $display("FAIL starve_order[%0d]: if_gnt=%b d_gnt=%b want if_gnt=%b", n, if_gnt, d_gnt, exp_if);
                end
                tests++;
                if (prev) begin
                    fails++; $display("FAIL starve_pulse[%0d]: grant held 2 cycles, want 1", n);
                end
                cnt = exp_if ? 0 : ((cnt < SL) ? cnt + 1 : SL);
                n++;
                prev = 1;
            end else begin
                prev = 0;
            end
        end
        tests++;
        if (n != 10) begin
            fails++; $display("FAIL starve_count: got %0d grants want 10", n);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) begin n = 1; break; end
        end
        tests++;
        if (n != 1) begin
            fails++; $display("FAIL starve_drain: busy=%b want 0", busy);
        end
    endtask

    task automatic test_misaligned();
        run_txn(0, 1, 32'h203, 32'h12345678, F3_H, 0, "store_h_203");
        run_txn(0, 0, 32'h0, 32'h0, 3'b011, 0, "load_f3_011");
        run_txn(1, 0, 32'h102, 32'h0, F3_W, 0, "fetch_misalign");
        run_txn(0, 0, 32'h207, 32'h0, F3_BU, 0, "load_bu_odd");
    endtask

    task automatic test_timeout();
        run_txn(1, 0, 32'h400, 32'h0, F3_W, 1000, "fetch_timeout");
        run_txn(1, 0, 32'h404, 32'h0, F3_W, 1, "fetch_after_to");
        run_txn(0, 0, 32'h300, 32'h0, F3_W, TO - 1, "ready_at_timeout");
    endtask

    task automatic test_reset_in_wait();
        bit bad;
        @(posedge clk); #1;
        mem_delay = 1000;
        if_req = 1'b1; if_addr = 32'h500;
        @(negedge clk);
        tests++;
        if (if_gnt !== 1'b1) begin
            fails++; $display("FAIL rst_wait_gnt: got %b want 1", if_gnt);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1) begin
            fails++; $display("FAIL rst_wait_memreq: got %b want 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_async_drop: mem_req=%b busy=%b want 0 0", mem_req, busy);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid || mem_req) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL rst_no_resp: stray rvalid or mem_req after reset, want none");
        end
        run_txn(1, 0, 32'h0, 32'h0, F3_W, 0, "post_reset_fetch");
    endtask

    task automatic test_random();
        int          delays[7];
        bit          is_fetch, we;
        logic [31:0] addr;
        delays = '{0, 0, 1, 2, 3, TO - 1, TO + 2};
        for (int i = 0; i < 30; i++) begin
            is_fetch = 1'($urandom);
            we       = 1'($urandom);
            addr     = $urandom & 32'h0000_0FFF;
            if (is_fetch && ($urandom % 4) != 0) addr[1:0] = 2'b00;
            run_txn(is_fetch, we, addr, $urandom, 3'($urandom),
                    delays[$urandom_range(0, 6)], $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_starvation();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
